// File: rtl/jtag_regbank_pkg.sv
// Shared definitions for the JTAG register bank: opcodes, TAP states and DR selection.
package jtag_regbank_pkg;

  localparam logic [31:0] IDCODE_DEF = 32'h1DA6_0001;

  localparam int OP_BYPASS = 0;
  localparam int OP_IDCODE = 1;
  localparam int OP_ADDR   = 2;
  localparam int OP_CFG    = 3;
  localparam int OP_STAT   = 4;

  typedef enum logic [3:0] {
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPD_DR,
    SEL_IR,
    CAP_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPD_IR
  } tap_state_e;

  typedef enum logic [2:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_ADDR,
    DR_CFG,
    DR_STAT
  } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller running in the clk domain, stepped by detected tck rises.
//
// state    | meaning
// ---------+------------------------------------------
// TLR      | Test-Logic-Reset, IR forced to IDCODE
// RTI      | Run-Test/Idle
// SEL_DR   | Select-DR-Scan
// CAP_DR   | Capture-DR, parallel load of selected DR
// SHIFT_DR | Shift-DR, serial shift of selected DR
// EXIT1_DR | Exit1-DR
// PAUSE_DR | Pause-DR
// EXIT2_DR | Exit2-DR
// UPD_DR   | Update-DR, commit shifted DR
// SEL_IR   | Select-IR-Scan
// CAP_IR   | Capture-IR, load ...01 pattern
// SHIFT_IR | Shift-IR
// EXIT1_IR | Exit1-IR
// PAUSE_IR | Pause-IR
// EXIT2_IR | Exit2-IR
// UPD_IR   | Update-IR, commit shifted IR
module jtag_tap_fsm
  import jtag_regbank_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tck_rise,
  input  logic       tms,
  input  logic       trst,
  output tap_state_e state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_e state_q;
  tap_state_e state_nxt;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= TLR;
    else     state_q <= state_nxt;
  end

  // next state on tck rise, trst overriding everything, plus state decodes
  always_comb begin
    state_nxt  = state_q;
    capture_dr = (state_q == CAP_DR);
    shift_dr   = (state_q == SHIFT_DR);
    update_dr  = (state_q == UPD_DR);
    capture_ir = (state_q == CAP_IR);
    shift_ir   = (state_q == SHIFT_IR);
    update_ir  = (state_q == UPD_IR);
    if (trst) begin
      state_nxt = TLR;
    end else if (tck_rise) begin
      case (state_q)
        TLR:      state_nxt = tms ? TLR      : RTI;
        RTI:      state_nxt = tms ? SEL_DR   : RTI;
        SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
        CAP_DR:   state_nxt = tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_nxt = tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_nxt = tms ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_nxt = tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_nxt = tms ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
        SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
        CAP_IR:   state_nxt = tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_nxt = tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_nxt = tms ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_nxt = tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_nxt = tms ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
        default:  state_nxt = TLR;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_regbank_os.sv
// JTAG-accessible config/status register bank, oversampling the pad JTAG pins with clk.
module jtag_regbank_os
  import jtag_regbank_pkg::*;
#(
  parameter int              IR_W    = 4,
  parameter int              NCFG    = 8,
  parameter int              NSTAT   = 8,
  parameter int              DW      = 32,
  parameter logic [31:0]     IDCODE  = IDCODE_DEF,
  parameter logic [DW-1:0]   CFG_RST = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tck,
  input  logic                       tms,
  input  logic                       tdi,
  input  logic                       trst_n,
  output logic                       tdo,
  output logic                       tdo_en,
  output logic [NCFG-1:0][DW-1:0]    cfg_q,
  output logic [NCFG-1:0]            cfg_wr,
  input  logic [NSTAT-1:0][DW-1:0]   stat_d,
  output logic                       stat_cap
);

  localparam int NMAX = (NCFG > NSTAT) ? NCFG : NSTAT;
  localparam int AW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  // one shift register serves every DR; it must hold the widest of IDCODE and the data words
  localparam int SRW  = (DW > 32) ? DW : 32;

  logic [1:0] tck_sy, tms_sy, tdi_sy, trst_sy;
  logic       tck_prev;
  logic       tck_rise, tck_fall;

  tap_state_e tap_state;
  logic       capture_dr, shift_dr, update_dr;
  logic       capture_ir, shift_ir, update_ir;

  logic [IR_W-1:0] ir, ir_sr;
  logic [SRW-1:0]  dr_sr, dr_cap, dr_msb;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   cfg_rd, stat_rd;
  dr_sel_e         dr_sel;

  // two-flop synchronisers for the pad pins and tck edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sy   <= '0;
      tms_sy   <= '0;
      tdi_sy   <= '0;
      trst_sy  <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sy   <= {tck_sy[0], tck};
      tms_sy   <= {tms_sy[0], tms};
      tdi_sy   <= {tdi_sy[0], tdi};
      trst_sy  <= {trst_sy[0], trst_n};
      tck_prev <= tck_sy[1];
    end
  end

  assign tck_rise = tck_sy[1] & ~tck_prev;
  assign tck_fall = ~tck_sy[1] & tck_prev;

  jtag_tap_fsm u_tap (
    .clk        (clk),
    .rst        (rst),
    .tck_rise   (tck_rise),
    .tms        (tms_sy[1]),
    .trst       (~trst_sy[1]),
    .state      (tap_state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir)
  );

  // opcode decode; anything unassigned falls back to bypass
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir == IR_W'(OP_BYPASS) || ir == '1) dr_sel = DR_BYPASS;
    else if (ir == IR_W'(OP_IDCODE))        dr_sel = DR_IDCODE;
    else if (ir == IR_W'(OP_ADDR))          dr_sel = DR_ADDR;
    else if (ir == IR_W'(OP_CFG))           dr_sel = DR_CFG;
    else if (ir == IR_W'(OP_STAT))          dr_sel = DR_STAT;
  end

  // addressed read muxes; an address with no register behind it reads as zero
  always_comb begin
    cfg_rd  = '0;
    stat_rd = '0;
    for (int i = 0; i < NCFG; i++)
      if (addr == AW'(i)) cfg_rd = cfg_q[i];
    for (int i = 0; i < NSTAT; i++)
      if (addr == AW'(i)) stat_rd = stat_d[i];
  end

  // capture value and tdi entry point (MSB of the selected register length)
  always_comb begin
    dr_msb = SRW'(1);
    dr_cap = '0;
    case (dr_sel)
      DR_IDCODE: begin dr_msb = SRW'(1) << 31;       dr_cap = SRW'(IDCODE);  end
      DR_ADDR:   begin dr_msb = SRW'(1) << (AW - 1); dr_cap = SRW'(addr);    end
      DR_CFG:    begin dr_msb = SRW'(1) << (DW - 1); dr_cap = SRW'(cfg_rd);  end
      DR_STAT:   begin dr_msb = SRW'(1) << (DW - 1); dr_cap = SRW'(stat_rd); end
      default:   ;
    endcase
  end

  // IR/DR capture and shift on tck rise, tdo and updates on tck fall
  always_ff @(posedge clk) begin
    if (rst) begin
      ir     <= IR_W'(OP_IDCODE);
      ir_sr  <= '0;
      dr_sr  <= '0;
      addr   <= '0;
      cfg_q  <= {NCFG{CFG_RST}};
      cfg_wr <= '0;
      tdo    <= 1'b0;
    end else begin
      cfg_wr <= '0;
      if (tap_state == TLR) ir <= IR_W'(OP_IDCODE);
      if (tck_rise) begin
        if (capture_ir) ir_sr <= IR_W'(1);
        if (shift_ir)   ir_sr <= {tdi_sy[1], ir_sr[IR_W-1:1]};
        if (capture_dr) dr_sr <= dr_cap;
        // bits above the selected length stay zero, so OR-ing tdi in at the MSB is safe
        if (shift_dr)   dr_sr <= (dr_sr >> 1) | (tdi_sy[1] ? dr_msb : '0);
      end
      if (tck_fall) begin
        if (shift_ir)      tdo <= ir_sr[0];
        else if (shift_dr) tdo <= dr_sr[0];
        if (update_ir) ir <= ir_sr;
        if (update_dr && dr_sel == DR_ADDR) addr <= dr_sr[AW-1:0];
        if (update_dr && dr_sel == DR_CFG) begin
          for (int i = 0; i < NCFG; i++) begin
            if (addr == AW'(i)) begin
              cfg_q[i]  <= dr_sr[DW-1:0];
              cfg_wr[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign tdo_en   = shift_dr | shift_ir;
  assign stat_cap = tck_rise & capture_dr & (dr_sel == DR_STAT) & ~rst;

endmodule

// File: tb/tb_jtag_regbank_os.sv
// Self-checking bench: randomized JTAG accesses against a register-level model.
module tb_jtag_regbank_os;

  localparam int NCFG  = 8;
  localparam int NSTAT = 16;
  localparam int DW    = 32;
  localparam int IR_W  = 4;
  localparam int AW    = 4;
  localparam logic [31:0] ID_WORD = 32'h1DA6_0001;

  logic clk = 1'b0;
  logic rst, tck, tms, tdi, trst_n;
  logic tdo, tdo_en, stat_cap;
  logic [NCFG-1:0][DW-1:0]  cfg_q;
  logic [NCFG-1:0]          cfg_wr;
  logic [NSTAT-1:0][DW-1:0] stat_d;

  always #5 clk = ~clk;

  jtag_regbank_os #(
    .IR_W  (IR_W),
    .NCFG  (NCFG),
    .NSTAT (NSTAT),
    .DW    (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .trst_n   (trst_n),
    .tdo      (tdo),
    .tdo_en   (tdo_en),
    .cfg_q    (cfg_q),
    .cfg_wr   (cfg_wr),
    .stat_d   (stat_d),
    .stat_cap (stat_cap)
  );

  int errors = 0;
  int checks = 0;

  // pulse monitors
  int              wr_pulses  = 0;
  int              cap_pulses = 0;
  logic [NCFG-1:0] wr_last    = '0;
  always @(negedge clk) begin
    if (cfg_wr != '0) begin
      wr_pulses++;
      wr_last = cfg_wr;
    end
    if (stat_cap === 1'b1) cap_pulses++;
  end

  // reference model
  logic [DW-1:0]   m_cfg [NCFG];
  logic [AW-1:0]   m_addr;
  logic [IR_W-1:0] m_ir;
  int              exp_wr, exp_cap;
  logic [NCFG-1:0] exp_last;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tck_cycle(input logic ms, input logic di, output logic o, output logic en);
    tck = 1'b0;
    tms = ms;
    tdi = di;
    repeat (6) @(posedge clk);
    #1;
    o  = tdo;
    en = tdo_en;
    tck = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) m_cfg[i] = '0;
    m_addr = '0;
    m_ir   = 4'd1;
  endtask

  task automatic check_cfg(input string tag);
    logic [NCFG-1:0][DW-1:0] mp;
    for (int i = 0; i < NCFG; i++) mp[i] = m_cfg[i];
    check_val(tag, cfg_q, mp);
  endtask

  // five tms=1 rises then park in Run-Test/Idle
  task automatic tap_reset();
    logic o, e;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, o, e);
    tck_cycle(1'b0, 1'b0, o, e);
    m_ir = 4'd1;
  endtask

  task automatic shift_ir(input logic [IR_W-1:0] op);
    logic o, e;
    logic [IR_W-1:0] cap;
    int bad;
    bad = 0;
    tck_cycle(1'b1, 1'b0, o, e); if (e) bad++;
    tck_cycle(1'b1, 1'b0, o, e); if (e) bad++;
    tck_cycle(1'b0, 1'b0, o, e); if (e) bad++;
    tck_cycle(1'b0, 1'b0, o, e); if (e) bad++;
    for (int i = 0; i < IR_W; i++) begin
      tck_cycle(i == IR_W - 1, op[i], o, e);
      cap[i] = o;
      if (!e) bad++;
    end
    tck_cycle(1'b1, 1'b0, o, e); if (e) bad++;
    tck_cycle(1'b0, 1'b0, o, e); if (e) bad++;
    check_val("ir_capture", cap, 4'b0001);
    check_val("ir_tdo_en", bad, 0);
    m_ir = op;
  endtask

  task automatic dr_access(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output int bad);
    logic o, e;
    dout = '0;
    bad  = 0;
    tck_cycle(1'b1, 1'b0, o, e); if (e) bad++;
    tck_cycle(1'b0, 1'b0, o, e); if (e) bad++;
    tck_cycle(1'b0, 1'b0, o, e); if (e) bad++;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], o, e);
      dout[i] = o;
      if (!e) bad++;
    end
    tck_cycle(1'b1, 1'b0, o, e); if (e) bad++;
    tck_cycle(1'b0, 1'b0, o, e); if (e) bad++;
  endtask

  // full DR scan: model captured word, serial stream, and register update
  task automatic do_dr(input string tag, input int n, input logic [63:0] din_raw);
    int len, bad;
    logic [31:0]  cap;
    logic [63:0]  din, dout, nmask, expout, fin;
    logic [127:0] v;
    nmask = (64'd1 << n) - 64'd1;
    din   = din_raw & nmask;
    case (m_ir)
      4'd1: begin len = 32; cap = ID_WORD; end
      4'd2: begin len = AW; cap = 32'(m_addr); end
      4'd3: begin len = 32; cap = (m_addr < NCFG) ? m_cfg[m_addr[2:0]] : 32'd0; end
      4'd4: begin len = 32; cap = stat_d[m_addr]; exp_cap++; end
      default: begin len = 1; cap = 32'd0; end
    endcase
    dr_access(n, din, dout, bad);
    v      = ({64'd0, din} << len) | 128'(cap);
    expout = v[63:0] & nmask;
    fin    = 64'(v >> n) & ((64'd1 << len) - 64'd1);
    if (m_ir == 4'd2) m_addr = fin[AW-1:0];
    if (m_ir == 4'd3 && m_addr < NCFG) begin
      m_cfg[m_addr[2:0]] = fin[DW-1:0];
      exp_wr++;
      exp_last = NCFG'(1) << m_addr;
    end
    check_val({tag, "_tdo"}, dout & nmask, expout);
    check_val({tag, "_tdo_en"}, bad, 0);
    check_cfg({tag, "_cfg_q"});
    check_val({tag, "_wr_pulses"}, wr_pulses, exp_wr);
    if (m_ir == 4'd3 && m_addr < NCFG) check_val({tag, "_wr_onehot"}, wr_last, exp_last);
    check_val({tag, "_stat_cap"}, cap_pulses, exp_cap);
  endtask

  initial begin
    logic o, e;
    int sel;
    tck = 1'b0; tms = 1'b0; tdi = 1'b0; trst_n = 1'b1; rst = 1'b1;
    stat_d = '0;
    exp_wr = 0; exp_cap = 0; exp_last = '0;
    model_reset();
    repeat (4) @(posedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_cfg("rst_cfg_q");
    check_val("rst_tdo", tdo, 1'b0);
    check_val("rst_tdo_en", tdo_en, 1'b0);
    check_val("rst_cfg_wr", cfg_wr, '0);
    check_val("rst_stat_cap", stat_cap, 1'b0);

    // IDCODE straight out of reset
    tck_cycle(1'b0, 1'b0, o, e);
    do_dr("idcode", 32, 64'($urandom));

    // address 5, then config write
    shift_ir(4'd2);
    do_dr("addr5", AW, 64'd5);
    shift_ir(4'd3);
    do_dr("cfg5", 32, 64'h0000_0000_CAFE_F00D);
    check_val("cfg5_wr_value", wr_last, 8'h20);
    check_val("cfg5_word", cfg_q[5], 32'hCAFE_F00D);

    // status read
    stat_d[3] = 32'h1234_5678;
    shift_ir(4'd2);
    do_dr("addr3", AW, 64'd3);
    shift_ir(4'd4);
    do_dr("stat3", 32, 64'($urandom));

    // out-of-range config address
    shift_ir(4'd2);
    do_dr("addr9", AW, 64'd9);
    shift_ir(4'd3);
    do_dr("cfg9_wr", 32, 64'hFFFF_FFFF);
    do_dr("cfg9_rd", 32, 64'($urandom));

    // bypass with all-ones IR: captured 0 then the shifted 1
    shift_ir(4'hF);
    do_dr("bypass_f", 2, 64'b01);

    // randomized accesses
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: begin shift_ir(4'd2); do_dr("rnd_addr", AW, 64'($urandom_range(0, 11))); end
        1: begin shift_ir(4'd3); do_dr("rnd_cfg", 32, 64'($urandom)); end
        2: begin
          for (int j = 0; j < NSTAT; j++) stat_d[j] = $urandom;
          shift_ir(4'd4);
          do_dr("rnd_stat", 32, 64'($urandom));
        end
        3: begin shift_ir(4'd1); do_dr("rnd_id", 32, 64'($urandom)); end
        4: begin
          if ($urandom_range(0, 1) == 0) shift_ir(4'd0);
          else shift_ir(4'($urandom_range(5, 15)));
          do_dr("rnd_byp", $urandom_range(1, 6), 64'($urandom));
        end
        default: begin shift_ir(4'd3); do_dr("rnd_long", 40, {$urandom, $urandom}); end
      endcase
    end

    // five tms=1 from inside Shift-IR
    shift_ir(4'd4);
    tck_cycle(1'b1, 1'b0, o, e);
    tck_cycle(1'b1, 1'b0, o, e);
    tck_cycle(1'b0, 1'b0, o, e);
    tck_cycle(1'b0, 1'b0, o, e);
    tck_cycle(1'b0, 1'b1, o, e);
    tap_reset();
    do_dr("tms_reset_id", 32, 64'($urandom));

    // trst mid Shift-DR of a config register
    shift_ir(4'd3);
    tck_cycle(1'b1, 1'b0, o, e);
    tck_cycle(1'b0, 1'b0, o, e);
    tck_cycle(1'b0, 1'b0, o, e);
    for (int i = 0; i < 5; i++) tck_cycle(1'b0, 1'b1, o, e);
    trst_n = 1'b0;
    tck_cycle(1'b0, 1'b0, o, e);
    trst_n = 1'b1;
    tck_cycle(1'b0, 1'b0, o, e);
    m_ir = 4'd1;
    do_dr("trst_id", 32, 64'($urandom));
    shift_ir(4'd2);
    do_dr("trst_addr", AW, 64'd2);

    // make sure config is non-reset before the rst abort
    shift_ir(4'd3);
    do_dr("pre_rst_cfg", 32, 64'h0000_0000_A5A5_0F0F);

    // rst mid Shift-DR
    tck_cycle(1'b1, 1'b0, o, e);
    tck_cycle(1'b0, 1'b0, o, e);
    tck_cycle(1'b0, 1'b0, o, e);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, o, e);
    tck = 1'b0;
    repeat (6) @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    model_reset();
    check_cfg("rst_mid_cfg_q");
    check_val("rst_mid_wr_pulses", wr_pulses, exp_wr);
    check_val("rst_mid_tdo_en", tdo_en, 1'b0);
    tck_cycle(1'b0, 1'b0, o, e);
    do_dr("post_rst_id", 32, 64'($urandom));
    shift_ir(4'd2);
    do_dr("post_rst_addr", AW, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
